// File: rtl/hwag_wheel_pkg.sv
// +----------------------------------------------------------------------+
// | hwag_wheel_pkg : shared constants and types for the trigger-wheel     |
// | emulator.                                            Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

package hwag_wheel_pkg;

    localparam int TEETH_DEF    = 60;
    localparam int MISSING_DEF  = 2;
    localparam int PERIOD_W_DEF = 16;
    localparam int CAM_ON_DEF   = 4;
    localparam int CAM_OFF_DEF  = 54;
    localparam int PERIOD_MIN   = 4;

    typedef logic [5:0]                tooth_idx_t;
    typedef logic [PERIOD_W_DEF-1:0]   pitch_t;
    typedef logic [PERIOD_W_DEF+1:0]   count_t;

endpackage

`default_nettype wire

// File: rtl/hwag_wheel_pitch.sv
// +----------------------------------------------------------------------+
// | hwag_wheel_pitch : tooth pitch register with clamp and, when          |
// | WHEEL_GEN_ACCEL_EN is defined, per-tooth saturating acceleration.     |
// |                                                      Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module hwag_wheel_pitch
    import hwag_wheel_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                tooth_start,
    input  logic [PERIOD_W-1:0] period,
    input  logic [7:0]          accel,
    output logic [PERIOD_W-1:0] pitch
);

    localparam logic [PERIOD_W-1:0] c_min = PERIOD_W'(PERIOD_MIN);

    logic [PERIOD_W-1:0] r_pitch;
    logic [PERIOD_W-1:0] w_clamped;
    logic [PERIOD_W-1:0] w_next;

    assign w_clamped = (period < c_min) ? c_min : period;

`ifdef WHEEL_GEN_ACCEL_EN
    logic                       r_loaded;
    logic signed [PERIOD_W+1:0] w_sum;
    logic [PERIOD_W-1:0]        w_sat;

    assign w_sum = $signed({2'b00, r_pitch}) + $signed({{(PERIOD_W-6){accel[7]}}, accel});

    // Negative sum -> floor, bit PERIOD_W set -> overflowed the pitch range.
    always_comb begin
        w_sat = w_sum[PERIOD_W-1:0];
        if (w_sum[PERIOD_W+1]) begin
            w_sat = c_min;
        end else if (w_sum[PERIOD_W]) begin
            w_sat = '1;
        end else if (w_sum[PERIOD_W-1:0] < c_min) begin
            w_sat = c_min;
        end
    end

    assign w_next = r_loaded ? w_sat : w_clamped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loaded <= 1'b0;
        end else if (ena && tooth_start) begin
            r_loaded <= 1'b1;
        end
    end
`else
    logic w_unused_accel;
    assign w_unused_accel = ^accel;
    assign w_next         = w_clamped;
`endif

    // The tooth that is just starting already uses the freshly sampled pitch.
    assign pitch = tooth_start ? w_next : r_pitch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pitch <= '0;
        end else if (ena && tooth_start) begin
            r_pitch <= w_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hwag_wheel_gen.sv
// +----------------------------------------------------------------------+
// | hwag_wheel_gen : 60-2 style crank tooth and cam phase generator.      |
// | Optional feature macro: WHEEL_GEN_ACCEL_EN.          Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module hwag_wheel_gen
    import hwag_wheel_pkg::*;
#(
    parameter int TEETH    = TEETH_DEF,
    parameter int MISSING  = MISSING_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int CAM_ON   = CAM_ON_DEF,
    parameter int CAM_OFF  = CAM_OFF_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [PERIOD_W-1:0] period,
    input  logic [7:0]          accel,
    output logic                vr_out,
    output logic                cam_out,
    output tooth_idx_t          tooth_idx,
    output logic                phase,
    output logic                rev_pulse
);

    localparam int CW = PERIOD_W + 2;
    localparam tooth_idx_t    c_last_tooth = tooth_idx_t'(TEETH - MISSING - 1);
    localparam tooth_idx_t    c_cam_on     = tooth_idx_t'(CAM_ON);
    localparam tooth_idx_t    c_cam_off    = tooth_idx_t'(CAM_OFF);
    localparam logic [CW-1:0] c_gap_mult   = CW'(MISSING + 1);
    localparam logic [CW-1:0] c_one        = CW'(1);

    logic [CW-1:0]       r_cnt;
    tooth_idx_t          r_tooth_idx;
    logic                r_phase;
    logic                r_vr;
    logic                r_cam;
    logic                r_rev;

    logic [PERIOD_W-1:0] w_pitch;
    logic [CW-1:0]       w_len;
    logic [CW-1:0]       w_half;
    logic [CW-1:0]       w_cnt_nxt;
    tooth_idx_t          w_idx_nxt;
    logic                w_tooth_start;
    logic                w_tooth_end;
    logic                w_last_tooth;
    logic                w_wrap;
    logic                w_phase_nxt;
    logic                w_vr_nxt;
    logic                w_cam_nxt;

    assign w_tooth_start = (r_cnt == '0);

    hwag_wheel_pitch #(
        .PERIOD_W    (PERIOD_W)
    ) u_pitch (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .tooth_start (w_tooth_start),
        .period      (period),
        .accel       (accel),
        .pitch       (w_pitch)
    );

    // The last real tooth absorbs the gap of the missing teeth.
    assign w_last_tooth = (r_tooth_idx == c_last_tooth);
    assign w_len        = w_last_tooth ? c_gap_mult * {2'b00, w_pitch} : {2'b00, w_pitch};
    assign w_half       = w_len >> 1;
    assign w_tooth_end  = (r_cnt == w_len - c_one);
    assign w_wrap       = w_tooth_end && w_last_tooth;
    assign w_cnt_nxt    = w_tooth_end ? '0 : r_cnt + c_one;

    always_comb begin
        w_idx_nxt = r_tooth_idx;
        if (w_wrap) begin
            w_idx_nxt = '0;
        end else if (w_tooth_end) begin
            w_idx_nxt = r_tooth_idx + tooth_idx_t'(1);
        end
    end

    // Outputs are computed from the next state so they line up with the counter.
    assign w_phase_nxt = r_phase ^ w_wrap;
    assign w_vr_nxt    = !w_tooth_end && (w_cnt_nxt >= w_half);
    assign w_cam_nxt   = w_phase_nxt && (w_idx_nxt >= c_cam_on) && (w_idx_nxt < c_cam_off);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_tooth_idx <= '0;
            r_phase     <= 1'b0;
            r_vr        <= 1'b0;
            r_cam       <= 1'b0;
            r_rev       <= 1'b0;
        end else if (ena) begin
            r_cnt       <= w_cnt_nxt;
            r_tooth_idx <= w_idx_nxt;
            r_phase     <= w_phase_nxt;
            r_vr        <= w_vr_nxt;
            r_cam       <= w_cam_nxt;
            r_rev       <= w_wrap;
        end
    end

    assign vr_out    = r_vr;
    assign cam_out   = r_cam;
    assign tooth_idx = r_tooth_idx;
    assign phase     = r_phase;
    assign rev_pulse = r_rev & ena;

endmodule

`default_nettype wire

// File: tb/tb_hwag_wheel_gen.sv
// +----------------------------------------------------------------------+
// | tb_hwag_wheel_gen : directed + randomized bench for hwag_wheel_gen    |
// | against a tooth-level reference model.               Revision: 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hwag_wheel_gen;

    localparam int REAL_TEETH = 58;
    localparam int GAP_MULT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic [15:0] period = 16'd64;
    logic [7:0]  accel = 8'd0;
    logic        vr_out;
    logic        cam_out;
    logic [5:0]  tooth_idx;
    logic        phase;
    logic        rev_pulse;

    hwag_wheel_gen dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .period    (period),
        .accel     (accel),
        .vr_out    (vr_out),
        .cam_out   (cam_out),
        .tooth_idx (tooth_idx),
        .phase     (phase),
        .rev_pulse (rev_pulse)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_cyc   = 0;
    int cam_cnt = 0;
    int rev_t[$];
    int cam_snap[$];

    // Reference model: position inside the current tooth and the tooth's length.
    int m_idx, m_phase, m_pos, m_len, m_p, m_rev, m_loaded;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_phase = 0; m_pos = 0; m_len = 0;
        m_p = 0; m_rev = 0; m_loaded = 0;
    endtask

    task automatic model_step();
        int a;
        if (m_pos == 0) begin
`ifdef WHEEL_GEN_ACCEL_EN
            if (m_loaded == 0) begin
                m_p = (int'(period) < 4) ? 4 : int'(period);
                m_loaded = 1;
            end else begin
                a   = $signed(accel);
                m_p = m_p + a;
                if (m_p < 4) m_p = 4;
                if (m_p > 65535) m_p = 65535;
            end
`else
            m_p = (int'(period) < 4) ? 4 : int'(period);
`endif
            m_len = (m_idx == REAL_TEETH - 1) ? GAP_MULT * m_p : m_p;
        end
        m_pos++;
        m_rev = 0;
        if (m_pos == m_len) begin
            m_pos = 0;
            m_idx++;
            if (m_idx == REAL_TEETH) begin
                m_idx   = 0;
                m_phase = 1 - m_phase;
                m_rev   = 1;
            end
        end
    endtask

    task automatic cyc();
        logic e_vr, e_cam, e_rev;
        @(posedge clk);
        #1;
        if (ena) model_step();
        n_cyc++;
        e_vr  = (m_pos != 0) && (m_pos >= m_len / 2);
        e_cam = (m_phase == 1) && (m_idx >= 4) && (m_idx < 54);
        e_rev = ena && (m_rev == 1);
        chk("vr_out", 32'(vr_out), 32'(e_vr));
        chk("cam_out", 32'(cam_out), 32'(e_cam));
        chk("tooth_idx", 32'(tooth_idx), 32'(m_idx));
        chk("phase", 32'(phase), 32'(m_phase));
        chk("rev_pulse", 32'(rev_pulse), 32'(e_rev));
        if (rev_pulse) begin
            rev_t.push_back(n_cyc);
            cam_snap.push_back(cam_cnt);
        end
        if (cam_out) cam_cnt++;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_vr", 32'(vr_out), 32'd0);
        chk("rst_cam", 32'(cam_out), 32'd0);
        chk("rst_idx", 32'(tooth_idx), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_rev", 32'(rev_pulse), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit hit;
        model_reset();
        #2;
        do_reset();

        // Full two revolutions at pitch 64.
        period = 16'd64; accel = 8'd0; ena = 1'b1;
        rev_t.delete(); cam_snap.delete();
        for (int i = 0; i < 9000 && rev_t.size() < 2; i++) cyc();
        if (rev_t.size() >= 2) begin
            chk("rev_len", 32'(rev_t[1] - rev_t[0]), 32'd3840);
            chk("cam_hi_cycles", 32'(cam_snap[1] - cam_snap[0]), 32'd3200);
        end else begin
            chk("rev_timeout", 32'(rev_t.size()), 32'd2);
        end

        // Pitch clamp, then a mid-tooth period change.
        do_reset();
        period = 16'd2;
        repeat (40) cyc();
        period = 16'd64;
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            cyc();
            hit = (m_pos == 10) && (m_idx < 50) && (m_len == 64);
        end
        chk("wait_pos10", 32'(hit), 32'd1);
        period = 16'd100;
        repeat (300) cyc();

        // Enable dropout mid-tooth.
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            cyc();
            hit = (m_pos == 20);
        end
        chk("wait_pos20", 32'(hit), 32'd1);
        ena = 1'b0;
        repeat (100) cyc();
        ena = 1'b1;
        repeat (200) cyc();

        // Reset at count 40 of tooth 30.
        hit = 1'b0;
        for (int i = 0; i < 12000 && !hit; i++) begin
            cyc();
            hit = (m_idx == 30) && (m_pos == 40);
        end
        chk("wait_t30", 32'(hit), 32'd1);
        do_reset();

        // Strong deceleration then mild acceleration (period-follow build ignores accel).
        period = 16'd100; accel = 8'h80;
        repeat (600) cyc();
        do_reset();
        period = 16'd64; accel = 8'd1;
        repeat (400) cyc();

        // Randomized stimulus.
        period = 16'($urandom_range(0, 40));
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 299) == 0) period = 16'($urandom_range(0, 40));
`ifdef WHEEL_GEN_ACCEL_EN
            if ($urandom_range(0, 299) == 0) accel = 8'($urandom_range(0, 6) - 3);
`else
            accel = 8'($urandom);
`endif
            ena = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 4999) == 0) do_reset();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hwag_wheel_gen.md
Name: hwag_wheel_gen

Overview:
Synthesizable crank/cam trigger-wheel emulator. It is the transmitter end of the capture path in `hwag`. It generates a 60-2 style VR-equivalent tooth signal and a cam phase signal from a programmable tooth pitch. It drives `hwag.cap_in` on the bench-board loopback and in self-test builds, so the capture path runs without an engine.

Parameters:
TEETH, 60, tooth positions per revolution including missing ones
MISSING, 2, missing teeth forming the gap (1..3)
PERIOD_W, 16, width of tooth pitch in clk cycles
CAM_ON, 4, tooth index where cam goes high (phase 1 only)
CAM_OFF, 54, tooth index where cam goes low (phase 1 only)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
ena  input  1  run enable; low freezes all state
period  input  PERIOD_W  tooth pitch in clk cycles
accel  input  8  signed per-tooth pitch increment (used only with WHEEL_GEN_ACCEL_EN)
vr_out  output  1  tooth signal to cap_in
cam_out  output  1  cam signal
tooth_idx  output  6  current real tooth, 0..TEETH-MISSING-1
phase  output  1  revolution parity (720 deg cycle)
rev_pulse  output  1  one-cycle pulse at start of tooth 0

Behaviour:
- Reset (async): vr_out=0, cam_out=0, tooth_idx=0, phase=0, rev_pulse=0, cycle counter=0. The tooth pitch register loads the clamped value of period on the first enabled cycle.
- Pitch sampling: period is sampled only at tooth start, so mid-tooth changes take effect from the next tooth. Effective pitch P=max(period,4).
- Tooth length L:
  - Real teeth 0..TEETH-MISSING-2: L=P.
  - Last real tooth (index TEETH-MISSING-1 = 57): L=(MISSING+1)*P, i.e. 192 for P=64.
  - Cycle counter width is PERIOD_W+2.
- vr_out:
  - Registered output.
  - Goes 0 on the first cycle of each tooth.
  - Goes 1 when the cycle counter reaches floor(L/2).
  - Stays 1 until the next tooth start.
- Tooth advance: when the counter reaches L-1 it returns to 0 and tooth_idx increments.
- Wrap: after tooth TEETH-MISSING-1, tooth_idx becomes 0, phase toggles, and rev_pulse=1 for exactly that first cycle of tooth 0.
- cam_out:
  - Registered. Equals 1 iff phase==1 and CAM_ON <= tooth_idx < CAM_OFF.
  - Transitions occur on the first cycle of the boundary tooth.
  - Stays 0 for the whole phase-0 revolution.
- ena=0: the counter, tooth_idx, phase, pitch and outputs hold their values, and rev_pulse is forced to 0. Resuming continues from the held count with no extra or lost cycles.
- Simultaneous events: a tooth start combined with a period change uses the new period. rst has priority over everything.
- Reset mid-tooth: outputs return to reset values immediately and asynchronously. Counting restarts at tooth 0, phase 0.

Optional Feature:
Macro: WHEEL_GEN_ACCEL_EN.
- With the macro:
  - The pitch register loads from period once after reset.
  - Thereafter, at each tooth start, pitch = pitch + sign-extended accel, saturated to [4, 2^PERIOD_W-1].
  - The period input is then ignored until the next reset.
  - This emulates engine acceleration and deceleration.
- Without the macro: the accel input is unused and pitch follows the period input as described above.

Decomposition:
- Package hwag_wheel_pkg:
  - PERIOD_MIN=4.
  - Defaults for TEETH, MISSING, CAM_ON, CAM_OFF.
  - Typedef of the tooth index (6 bits).
  - Typedef of the pitch (PERIOD_W bits) and the extended count (PERIOD_W+2 bits).
- One sub-module, hwag_wheel_pitch, holds the pitch register, the clamp, and the accel saturation logic (macro-dependent). The top level holds the counter, tooth index, phase and output registers.

Test Plan:
1. Reset release, period=64, ena=1 -> vr_out rises 32 cycles after each tooth start, one tooth every 64 cycles, tooth_idx increments 0→1→2.
2. Run through tooth 57 -> that tooth lasts 192 cycles (vr low 96 / high 96). Then tooth_idx=0, rev_pulse high for exactly 1 cycle, phase toggles. A full revolution is 58*64+128 = 3840 cycles.
3. Two revolutions -> cam_out=0 throughout the phase-0 revolution. In the phase-1 revolution cam_out goes high at the start of tooth 4 and low at the start of tooth 54, i.e. high for 3200 cycles.
4. period=2 -> pitch clamps to 4 (vr high after 2 cycles). Change period from 64 to 100 at cycle 10 of a tooth -> the current tooth still lasts 64 cycles and the next lasts 100.
5. Drop ena for 100 cycles at count 20 -> all outputs frozen, tooth completes 44 cycles after re-enable. Assert rst at count 40 of tooth 30 -> all outputs 0 immediately, tooth_idx=0.
6. With WHEEL_GEN_ACCEL_EN, period=64, accel=+1 -> successive teeth last 64, 65, 66 cycles. With accel=-128 from pitch 100 -> pitch saturates at 4.
